// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared activation types, defaults and the per-lane activation function
package act_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        RELU   = 2'd1,
        LEAKY  = 2'd2,
        CLIP   = 2'd3
    } act_mode_e;

    localparam int ACT_DATA_W = 23;
    localparam int ACT_LANES  = 1;

    // Lanes are sign-extended to this width so one function serves every DATA_W below it.
    localparam int ACT_MAX_W  = 64;

    function automatic logic signed [ACT_MAX_W-1:0] activate(
        input logic signed [ACT_MAX_W-1:0] x,
        input act_mode_e                   mode,
        input logic signed [ACT_MAX_W-1:0] clip_max,
        input int                          leak_shift
    );
        logic signed [ACT_MAX_W-1:0] r;
        r = x;
        case (mode)
            RELU:    if (x[ACT_MAX_W-1]) r = '0;
            LEAKY:   if (x[ACT_MAX_W-1]) r = x >>> leak_shift;
            CLIP: begin
                if (x[ACT_MAX_W-1])    r = '0;
                else if (x > clip_max) r = clip_max;
            end
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic lane_zeroed(input logic x_neg, input act_mode_e mode);
        return x_neg && (mode == RELU || mode == CLIP);
    endfunction

endpackage

// File: rtl/act_skid_buf.sv
// rtl/act_skid_buf.sv - output register plus one skid entry with a registered in_ready
import act_pkg::*;

module act_skid_buf #(
    parameter int PAYLOAD_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] payload_in,
    output logic                 valid_out,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] payload_out
);

    logic [PAYLOAD_W-1:0] skid_q;
    logic                 skid_full;

    logic                 accept;
    logic                 valid_d;
    logic [PAYLOAD_W-1:0] payload_d;
    logic [PAYLOAD_W-1:0] skid_d;
    logic                 skid_full_d;

    assign accept = valid_in && in_ready;

    always_comb begin
        valid_d     = valid_out;
        payload_d   = payload_out;
        skid_d      = skid_q;
        skid_full_d = skid_full;
        if (!valid_out || out_ready) begin
            // in_ready is low whenever the skid is full, so no new beat competes here.
            if (skid_full) begin
                valid_d     = 1'b1;
                payload_d   = skid_q;
                skid_full_d = 1'b0;
            end else begin
                valid_d = accept;
                if (accept) payload_d = payload_in;
            end
        end else if (accept) begin
            skid_d      = payload_in;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out   <= 1'b0;
            payload_out <= '0;
            skid_q      <= '0;
            skid_full   <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            valid_out   <= valid_d;
            payload_out <= payload_d;
            skid_q      <= skid_d;
            skid_full   <= skid_full_d;
            in_ready    <= !skid_full_d;
        end
    end

endmodule

// File: rtl/act_unit.sv
// rtl/act_unit.sv - multi-lane selectable activation stage with skid buffering and zero counter
import act_pkg::*;

module act_unit #(
    parameter int DATA_W     = ACT_DATA_W,
    parameter int LANES      = ACT_LANES,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] data_in,
    input  logic [1:0]              mode,
    input  logic [DATA_W-2:0]       clip_max,
    output logic                    valid_out,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] data_out,
    input  logic                    stat_clr,
    output logic [CNT_W-1:0]        zero_count
);

    localparam int PAYLOAD_W = LANES * DATA_W + LANES;
    localparam int PC_W      = $clog2(LANES + 1);
    localparam int SUM_W     = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

    act_mode_e                   mode_e;
    logic signed [ACT_MAX_W-1:0] clip_ext;
    logic [LANES*DATA_W-1:0]     act_data;
    logic [LANES-1:0]            zero_flag;
    logic [PAYLOAD_W-1:0]        payload_out;
    logic [LANES-1:0]            out_zero;
    logic                        emit;
    logic [PC_W-1:0]             zero_pop;
    logic [SUM_W-1:0]            zero_sum;

    assign mode_e   = act_mode_e'(mode);
    assign clip_ext = {{(ACT_MAX_W - DATA_W + 1){1'b0}}, clip_max};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [ACT_MAX_W-1:0] x_ext;
        logic signed [ACT_MAX_W-1:0] y_ext;
        always_comb begin
            x_ext = {{(ACT_MAX_W - DATA_W){data_in[i*DATA_W + DATA_W - 1]}},
                     data_in[i*DATA_W +: DATA_W]};
            y_ext = activate(x_ext, mode_e, clip_ext, LEAK_SHIFT);
        end
        // Every mode's result fits back into DATA_W, so plain truncation is exact.
        assign act_data[i*DATA_W +: DATA_W] = y_ext[DATA_W-1:0];
        assign zero_flag[i] = lane_zeroed(x_ext[ACT_MAX_W-1], mode_e);
    end

    act_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .in_ready    (in_ready),
        .payload_in  ({zero_flag, act_data}),
        .valid_out   (valid_out),
        .out_ready   (out_ready),
        .payload_out (payload_out)
    );

    assign data_out = payload_out[LANES*DATA_W-1:0];
    assign out_zero = payload_out[PAYLOAD_W-1 -: LANES];
    assign emit     = valid_out && out_ready;

    always_comb begin
        zero_pop = '0;
        for (int i = 0; i < LANES; i++) zero_pop += PC_W'(out_zero[i]);
        zero_sum = SUM_W'(zero_count) + SUM_W'(zero_pop);
        if (zero_sum > CNT_MAX) zero_sum = CNT_MAX;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_count <= '0;
        end else if (stat_clr) begin
            zero_count <= '0;
        end else if (emit) begin
            zero_count <= zero_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_act_unit.sv
// tb/tb_act_unit.sv - randomized and directed check of act_unit against a queue-based reference
module tb_act_unit;

    localparam int DW = 23;
    localparam int LN = 4;
    localparam int LS = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in;
    logic              out_ready;
    logic              stat_clr;
    logic [LN*DW-1:0]  data_in;
    logic [1:0]        mode;
    logic [DW-2:0]     clip_max;

    logic              in_ready_a, valid_out_a;
    logic [LN*DW-1:0]  data_out_a;
    logic [15:0]       zc_a;
    logic              in_ready_b, valid_out_b;
    logic [DW-1:0]     data_out_b;
    logic [3:0]        zc_b;

    always #5 clk = ~clk;

    act_unit #(.DATA_W(DW), .LANES(LN), .LEAK_SHIFT(LS), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .valid_in(valid_in), .in_ready(in_ready_a),
        .data_in(data_in), .mode(mode), .clip_max(clip_max),
        .valid_out(valid_out_a), .out_ready(out_ready), .data_out(data_out_a),
        .stat_clr(stat_clr), .zero_count(zc_a)
    );

    act_unit #(.DATA_W(DW), .LANES(1), .LEAK_SHIFT(LS), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .valid_in(valid_in), .in_ready(in_ready_b),
        .data_in(data_in[DW-1:0]), .mode(mode), .clip_max(clip_max),
        .valid_out(valid_out_b), .out_ready(out_ready), .data_out(data_out_b),
        .stat_clr(stat_clr), .zero_count(zc_b)
    );

    typedef struct {
        logic [LN*DW-1:0] data;
        int               za;
        int               zb;
    } beat_t;

    beat_t  exp_q[$];
    int     vectors     = 0;
    int     miscompares = 0;
    longint cnt_a       = 0;
    longint cnt_b       = 0;
    bit     rdy_seen    = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint ref_lane(input longint x, input int m, input longint cmax);
        longint div;
        div = longint'(1) << LS;
        case (m)
            0:       return x;
            1:       return (x < 0) ? 0 : x;
            2:       return (x < 0) ? -((-x + div - 1) / div) : x;
            default: return (x < 0) ? 0 : ((x > cmax) ? cmax : x);
        endcase
    endfunction

    function automatic beat_t make_beat(input logic [LN*DW-1:0] d, input logic [1:0] m,
                                        input logic [DW-2:0] cm);
        beat_t  b;
        longint x;
        longint r;
        b.za = 0;
        b.zb = 0;
        for (int i = 0; i < LN; i++) begin
            x = longint'($signed(d[i*DW +: DW]));
            r = ref_lane(x, int'(m), longint'(cm));
            b.data[i*DW +: DW] = DW'(r);
            if ((m == 2'd1 || m == 2'd3) && x < 0) begin
                b.za++;
                if (i == 0) b.zb++;
            end
        end
        return b;
    endfunction

    function automatic logic [LN*DW-1:0] pack4(input longint l0, input longint l1,
                                               input longint l2, input longint l3);
        logic [LN*DW-1:0] d;
        d[0*DW +: DW] = DW'(l0);
        d[1*DW +: DW] = DW'(l1);
        d[2*DW +: DW] = DW'(l2);
        d[3*DW +: DW] = DW'(l3);
        return d;
    endfunction

    // Reference: a queue of held beats; at most two can be in flight.
    always @(negedge clk) begin
        beat_t         h;
        bit            exp_rdy;
        logic [DW-1:0] lane0;
        if (rst) begin
            exp_q.delete();
            cnt_a    = 0;
            cnt_b    = 0;
            rdy_seen = 0;
            check("rst_valid_out", valid_out_a, 0);
            check("rst_in_ready", in_ready_a, 0);
            check("rst_data_out", data_out_a, 0);
            check("rst_zc_a", zc_a, 0);
            check("rst_zc_b", zc_b, 0);
        end else begin
            exp_rdy = rdy_seen && (exp_q.size() < 2);
            check("in_ready_a", in_ready_a, exp_rdy);
            check("in_ready_b", in_ready_b, exp_rdy);
            check("valid_out_a", valid_out_a, exp_q.size() > 0);
            check("valid_out_b", valid_out_b, exp_q.size() > 0);
            check("zero_count_a", zc_a, cnt_a);
            check("zero_count_b", zc_b, cnt_b);
            if (exp_q.size() > 0) begin
                h     = exp_q[0];
                lane0 = h.data[DW-1:0];
                check("data_out_a", data_out_a, h.data);
                check("data_out_b", data_out_b, lane0);
            end
            if (exp_q.size() > 0 && out_ready) begin
                h = exp_q.pop_front();
                if (!stat_clr) begin
                    cnt_a = (cnt_a + h.za > 65535) ? 65535 : cnt_a + h.za;
                    cnt_b = (cnt_b + h.zb > 15) ? 15 : cnt_b + h.zb;
                end
            end
            if (stat_clr) begin
                cnt_a = 0;
                cnt_b = 0;
            end
            if (valid_in && exp_rdy) exp_q.push_back(make_beat(data_in, mode, clip_max));
            rdy_seen = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [LN*DW-1:0] d, input logic [1:0] m);
        int n = 0;
        bit acc;
        data_in  = d;
        mode     = m;
        valid_in = 1'b1;
        do begin
            acc = in_ready_a;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) check("send_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
        data_in = '0; mode = 2'd0; clip_max = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("ready_before_edge", in_ready_a, 0);
        tick();
        check("ready_after_edge", in_ready_a, 1);

        send(pack4(500, 0, 0, 0), 2'd1);   check("t1_500", data_out_b, DW'(500));
        send(pack4(-300, 0, 0, 0), 2'd1);  check("t1_neg", data_out_b, 0);
        send(pack4(0, 0, 0, 0), 2'd1);     check("t1_zero", data_out_b, 0);
        valid_in = 1'b0; tick();
        check("t1_zc", zc_b, 1);

        send(pack4(-8, -1, 16, -100), 2'd2);
        check("t2_leaky", data_out_a, pack4(-1, -1, 16, -13));
        send(pack4(-8, -1, 16, -100), 2'd0);
        check("t2_bypass", data_out_a, pack4(-8, -1, 16, -100));

        clip_max = (DW-1)'(255);
        send(pack4(300, -5, 255, 100), 2'd3);
        check("t3_clip", data_out_a, pack4(255, 0, 255, 100));
        valid_in = 1'b0; tick();
        check("t3_zc", zc_a, 2);

        send(pack4(10, 0, 0, 0), 2'd0);
        out_ready = 1'b0;
        send(pack4(20, 0, 0, 0), 2'd0);
        data_in = pack4(30, 0, 0, 0);
        repeat (3) tick();
        check("t4_hold", data_out_b, DW'(10));
        check("t4_stall_ready", in_ready_a, 0);
        out_ready = 1'b1;
        send(pack4(30, 0, 0, 0), 2'd0);
        send(pack4(40, 0, 0, 0), 2'd0);
        valid_in = 1'b0; repeat (4) tick();

        send(pack4(10, 0, 0, 0), 2'd1);
        valid_in = 1'b0; data_in = pack4(99, 0, 0, 0); tick();
        send(pack4(-20, 0, 0, 0), 2'd1);
        valid_in = 1'b0; repeat (3) tick();

        out_ready = 1'b0;
        send(pack4(-1, -2, 3, 4), 2'd1);
        send(pack4(-5, 6, 7, 8), 2'd1);
        valid_in = 1'b0; tick();
        rst = 1'b1; #1;
        check("t6_rst_valid", valid_out_a, 0);
        check("t6_rst_zc", zc_a, 0);
        tick(); rst = 1'b0; out_ready = 1'b1;
        tick();
        check("t6_ready_back", in_ready_a, 1);

        send(pack4(-3, 0, 0, 0), 2'd1);
        valid_in = 1'b0; tick();
        stat_clr = 1'b1;
        send(pack4(-4, -4, 0, 0), 2'd1);
        valid_in = 1'b0; tick();
        stat_clr = 1'b0;
        check("t6_clr_wins", zc_a, 0);

        for (int i = 0; i < 20; i++) send(pack4(-5, -6, -7, -8), 2'd1);
        valid_in = 1'b0; tick();
        check("t6_sat_b", zc_b, 15);
        check("t6_cnt_a", zc_a, 80);

        for (int c = 0; c < 3000; c++) begin
            valid_in  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            mode      = 2'($urandom);
            clip_max  = ($urandom % 2) ? (DW-1)'($urandom) : (DW-1)'($urandom_range(0, 300));
            stat_clr  = ($urandom % 64) == 0;
            rst       = ($urandom % 500) == 0;
            for (int l = 0; l < LN; l++) begin
                if ($urandom % 2) data_in[l*DW +: DW] = DW'($urandom);
                else data_in[l*DW +: DW] = DW'(longint'($urandom_range(0, 600)) - 300);
            end
            tick();
        end
        rst = 1'b0; valid_in = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
        repeat (5) tick();
        check("drained", valid_out_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
